// File: rtl/stat_pkg.sv
// Shared definitions for the MAX/MIN/AVG statistics sequencer.
//   DW_DEF     : default data / element-count width
//   SW_DEF     : default running-sum width (must be >= 2*DW_DEF so the sum never wraps)
//   DIV_CYCLES : cycles the restoring divider needs (one quotient bit per cycle)
//   state_e    : sequencer FSM encoding
package stat_pkg;

  localparam int DW_DEF     = 8;
  localparam int SW_DEF     = 16;
  localparam int DIV_CYCLES = SW_DEF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    DIV,
    DONE
  } state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Ports:
//   clk_i, rst_i  : clock and synchronous active-high reset (aborts a divide)
//   start_i       : one-cycle pulse; captures dividend_i / divisor_i
//   dividend_i    : SW-bit unsigned dividend
//   divisor_i     : DW-bit unsigned divisor (must be non-zero)
//   done_o        : high during the final iteration cycle
//   quotient_o    : low DW bits of the quotient, valid while done_o is high
// The caller guarantees the quotient fits in DW bits.
module seq_divider
  import stat_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int SW     = SW_DEF,
  parameter int CYCLES = DIV_CYCLES
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [SW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic          done_o,
  output logic [DW-1:0] quotient_o
);

  localparam int CW = $clog2(CYCLES + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] dq_q, dq_d;     // dividend shifts out the top, quotient shifts in the bottom
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] dvs_q, dvs_d;

  logic [DW:0]   rem_sh;
  logic [DW:0]   diff;
  logic          fits;
  logic [SW-1:0] q_nx;

  // The partial remainder is always below the divisor, so the shifted value
  // is below twice the divisor: the borrow bit of the trial subtraction alone
  // says whether the divisor fits.
  assign rem_sh = {rem_q, dq_q[SW-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign fits   = ~diff[DW];
  assign q_nx   = {dq_q[SW-2:0], fits};

  assign done_o     = busy_q && (cnt_q == CW'(1));
  assign quotient_o = q_nx[DW-1:0];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    busy_d = busy_q;
    cnt_d  = cnt_q;
    dq_d   = dq_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CW'(CYCLES);
      dq_d   = dividend_i;
      rem_d  = '0;
      dvs_d  = divisor_i;
    end else if (busy_q) begin
      dq_d  = q_nx;
      rem_d = fits ? diff[DW-1:0] : rem_sh[DW-1:0];
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      dq_q   <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      dq_q   <= dq_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

endmodule

// File: rtl/stat_sequencer.sv
// Loop controller and statistics datapath for the MAX/MIN/AVG ASIP.
// Drives an external CountRegister (load/decrement, watches its zero flag),
// consumes a valid/ready byte stream and reports max, min, sum and floor(avg).
// Ports:
//   CLK, RESET            : clock, synchronous active-high reset
//   start, n_in           : run request (sampled only in IDLE) and element count N
//   data_in, data_valid   : input stream; data_ready is the accept strobe
//   Count_in, Count_load  : registered N and its one-cycle load pulse
//   Count_dec             : one pulse per consumed element
//   zero_flag             : CountRegister reports count == 0
//   max_out, min_out, sum_out, avg_out : results, valid from done until next start
//   busy, done            : not-idle indicator, one-cycle completion pulse
module stat_sequencer
  import stat_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          start,
  input  logic [DW-1:0] n_in,
  input  logic [DW-1:0] data_in,
  input  logic          data_valid,
  output logic          data_ready,
  output logic [DW-1:0] Count_in,
  output logic          Count_load,
  output logic          Count_dec,
  input  logic          zero_flag,
  output logic [DW-1:0] max_out,
  output logic [DW-1:0] min_out,
  output logic [SW-1:0] sum_out,
  output logic [DW-1:0] avg_out,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [DW-1:0] count_q, count_d;
  logic [DW-1:0] max_q, max_d;
  logic [DW-1:0] min_q, min_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [DW-1:0] avg_q, avg_d;

  logic          div_start;
  logic          div_done;
  logic [DW-1:0] div_quot;
  logic          xfer;

  // Handshake strobes are gated by RESET so they drop in the reset cycle
  // itself rather than one edge later.
  assign data_ready = (state_q == FETCH) && !zero_flag && !RESET;
  assign Count_load = (state_q == LOAD) && !RESET;
  assign xfer       = data_valid && data_ready;
  assign Count_dec  = xfer;

  assign Count_in = count_q;
  assign max_out  = max_q;
  assign min_out  = min_q;
  assign sum_out  = sum_q;
  assign avg_out  = avg_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    max_d     = max_q;
    min_d     = min_q;
    sum_d     = sum_q;
    avg_d     = avg_q;
    div_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          count_d = n_in;
          max_d   = '0;
          sum_d   = '0;
          avg_d   = '0;
          if (n_in != '0) begin
            min_d   = '1;
            state_d = LOAD;
          end else begin
            // Empty run: report all-zero results without touching the stream.
            min_d   = '0;
            state_d = DONE;
          end
        end
      end
      LOAD: state_d = FETCH;
      FETCH: begin
        if (zero_flag) begin
          div_start = 1'b1;
          state_d   = DIV;
        end else if (xfer) begin
          if (data_in > max_q) max_d = data_in;
          if (data_in < min_q) min_d = data_in;
          sum_d = sum_q + {{(SW-DW){1'b0}}, data_in};
        end
      end
      DIV: begin
        if (div_done) begin
          avg_d   = div_quot;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the result registers are reset, not just the FSM, because the
  // outputs must read zero after reset rather than holding stale results.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      count_q <= '0;
      max_q   <= '0;
      min_q   <= '0;
      sum_q   <= '0;
      avg_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      max_q   <= max_d;
      min_q   <= min_d;
      sum_q   <= sum_d;
      avg_q   <= avg_d;
    end
  end

  seq_divider #(
    .DW     (DW),
    .SW     (SW),
    .CYCLES (SW)
  ) u_div (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .start_i    (div_start),
    .dividend_i (sum_q),
    .divisor_i  (count_q),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

endmodule

// File: tb/tb_stat_sequencer.sv
// Self-checking bench for stat_sequencer: table-driven runs, randomized runs
// checked against a reference model, and hand-written reset / busy-start
// sequences. Includes a behavioural CountRegister.
module tb_stat_sequencer;

  localparam int DW = 8;
  localparam int SW = 16;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          start;
  logic [DW-1:0] n_in;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic [DW-1:0] Count_in;
  logic          Count_load;
  logic          Count_dec;
  logic          zero_flag;
  logic [DW-1:0] max_out;
  logic [DW-1:0] min_out;
  logic [SW-1:0] sum_out;
  logic [DW-1:0] avg_out;
  logic          busy;
  logic          done;

  always #5 CLK = ~CLK;

  stat_sequencer #(.DW(DW), .SW(SW)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .start      (start),
    .n_in       (n_in),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .Count_in   (Count_in),
    .Count_load (Count_load),
    .Count_dec  (Count_dec),
    .zero_flag  (zero_flag),
    .max_out    (max_out),
    .min_out    (min_out),
    .sum_out    (sum_out),
    .avg_out    (avg_out),
    .busy       (busy),
    .done       (done)
  );

  // CountRegister: load/dec at the edge, zero flag from the registered count.
  logic [DW-1:0] cr_q = '0;
  always @(posedge CLK) begin
    if (RESET)           cr_q <= '0;
    else if (Count_load) cr_q <= Count_in;
    else if (Count_dec)  cr_q <= cr_q - 8'd1;
  end
  assign zero_flag = (cr_q == '0);

  // Pulse monitors (free-running; tests compare deltas).
  int load_cnt = 0, dec_cnt = 0, ready_cnt = 0, done_cnt = 0, ov_cnt = 0;
  always @(posedge CLK) begin
    if (Count_load)              load_cnt  <= load_cnt + 1;
    if (Count_dec)               dec_cnt   <= dec_cnt + 1;
    if (data_ready)              ready_cnt <= ready_cnt + 1;
    if (done)                    done_cnt  <= done_cnt + 1;
    if (Count_load && Count_dec) ov_cnt    <= ov_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Stream driver state.
  logic [7:0] stim[$];
  int gap_len  = 0;
  int idx      = 0;
  int gapcnt   = 0;
  int poke_cyc = 0;
  int load0, dec0, ready0, done0, ov0;

  // Presents the next element (after gap_len idle cycles), advances one edge,
  // then samples #1 after the edge.
  task automatic drive_cycle();
    bit acc;
    if (idx < stim.size() && gapcnt >= gap_len) begin
      data_valid = 1'b1;
      data_in    = stim[idx];
    end else begin
      data_valid = 1'b0;
      data_in    = 8'($urandom);
    end
    acc = data_valid && data_ready;
    @(posedge CLK);
    #1;
    if (acc) begin
      idx++;
      gapcnt = 0;
    end else if (!data_valid) begin
      gapcnt++;
    end
  endtask

  task automatic begin_run(input logic [7:0] n);
    idx    = 0;
    gapcnt = 0;
    load0  = load_cnt;
    dec0   = dec_cnt;
    ready0 = ready_cnt;
    done0  = done_cnt;
    ov0    = ov_cnt;
    start  = 1'b1;
    n_in   = n;
    drive_cycle();
    start  = 1'b0;
    n_in   = 8'($urandom);
  endtask

  task automatic run_to_done(input int limit, output int lat);
    lat = 1;
    while (!done && lat < limit) begin
      if (lat == poke_cyc) begin
        start = 1'b1;
        n_in  = 8'd7;
      end
      drive_cycle();
      start = 1'b0;
      lat++;
    end
  endtask

  task automatic finish_checks(input string tag, input int n,
                               input logic [7:0] emx, input logic [7:0] emn,
                               input logic [7:0] eav, input logic [15:0] esm,
                               input int elat, input int lat);
    check({tag, " done"},      done, 1);
    check({tag, " max"},       max_out, emx);
    check({tag, " min"},       min_out, emn);
    check({tag, " sum"},       sum_out, esm);
    check({tag, " avg"},       avg_out, eav);
    check({tag, " count_in"},  Count_in, n);
    check({tag, " dec_pulses"}, dec_cnt - dec0, n);
    check({tag, " load_pulses"}, load_cnt - load0, (n != 0) ? 1 : 0);
    check({tag, " load_dec_overlap"}, ov_cnt - ov0, 0);
    check({tag, " consumed"},  idx, n);
    if (n == 0) check({tag, " ready_cycles"}, ready_cnt - ready0, 0);
    if (elat != 0) check({tag, " latency"}, lat, elat);
    drive_cycle();
    check({tag, " done_one_cycle"}, done, 0);
    check({tag, " idle_after"}, busy, 0);
    drive_cycle();
    check({tag, " sum_hold"}, sum_out, esm);
    check({tag, " avg_hold"}, avg_out, eav);
    check({tag, " done_pulses"}, done_cnt - done0, 1);
  endtask

  // Reference model: plain statistics over the element list.
  task automatic model(input logic [7:0] q[$], output logic [7:0] mx,
                       output logic [7:0] mn, output logic [7:0] av,
                       output logic [15:0] sm);
    int s = 0;
    int hi = 0;
    int lo = (q.size() != 0) ? 255 : 0;
    foreach (q[i]) begin
      s += int'(q[i]);
      if (int'(q[i]) > hi) hi = int'(q[i]);
      if (int'(q[i]) < lo) lo = int'(q[i]);
    end
    mx = 8'(hi);
    mn = 8'(lo);
    sm = 16'(s);
    av = (q.size() != 0) ? 8'(s / q.size()) : 8'd0;
  endtask

  // Vector table. Element i of d is byte i counted from the right; when n > 8
  // every element equals d[0].
  typedef struct packed {
    logic [7:0]       n;
    logic [3:0]       gap;
    logic [7:0][7:0]  d;
    logic [7:0]       mx;
    logic [7:0]       mn;
    logic [7:0]       av;
    logic [15:0]      sm;
    logic [15:0]      lat;   // 0: latency not checked
    logic [7:0]       poke;  // cycle at which a stray start is pulsed, 0: none
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;
    logic [7:0]  mx, mn, av;
    logic [15:0] sm;

    vecs[0] = '{n:8'd5,   gap:4'd0, d:{8'd0, 8'd0, 8'd0, 8'd5, 8'd1, 8'd9, 8'd3, 8'd7},
                mx:8'd9,   mn:8'd1,   av:8'd5,   sm:16'd25,    lat:16'd24,  poke:8'd0};
    vecs[1] = '{n:8'd3,   gap:4'd3, d:{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd254, 8'd255, 8'd200},
                mx:8'd255, mn:8'd200, av:8'd236, sm:16'd709,   lat:16'd0,   poke:8'd0};
    vecs[2] = '{n:8'd0,   gap:4'd0, d:64'd0,
                mx:8'd0,   mn:8'd0,   av:8'd0,   sm:16'd0,     lat:16'd1,   poke:8'd0};
    vecs[3] = '{n:8'd1,   gap:4'd0, d:64'd0,
                mx:8'd0,   mn:8'd0,   av:8'd0,   sm:16'd0,     lat:16'd20,  poke:8'd0};
    vecs[4] = '{n:8'd255, gap:4'd0, d:{56'd0, 8'd255},
                mx:8'd255, mn:8'd255, av:8'd255, sm:16'd65025, lat:16'd274, poke:8'd0};
    vecs[5] = '{n:8'd3,   gap:4'd0, d:{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd30, 8'd20, 8'd10},
                mx:8'd30,  mn:8'd10,  av:8'd20,  sm:16'd60,    lat:16'd22,  poke:8'd3};
    vecs[6] = '{n:8'd3,   gap:4'd0, d:{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd30, 8'd20, 8'd10},
                mx:8'd30,  mn:8'd10,  av:8'd20,  sm:16'd60,    lat:16'd22,  poke:8'd12};

    RESET      = 1'b1;
    start      = 1'b0;
    n_in       = '0;
    data_in    = '0;
    data_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset busy",       busy, 0);
    check("reset done",       done, 0);
    check("reset data_ready", data_ready, 0);
    check("reset count_load", Count_load, 0);
    check("reset count_dec",  Count_dec, 0);
    check("reset count_in",   Count_in, 0);
    check("reset max",        max_out, 0);
    check("reset min",        min_out, 0);
    check("reset sum",        sum_out, 0);
    check("reset avg",        avg_out, 0);
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Table-driven runs.
    for (int v = 0; v < 7; v++) begin
      stim.delete();
      for (int i = 0; i < int'(vecs[v].n); i++)
        stim.push_back((vecs[v].n > 8 || i >= 8) ? vecs[v].d[0] : vecs[v].d[i]);
      gap_len  = int'(vecs[v].gap);
      poke_cyc = int'(vecs[v].poke);
      begin_run(vecs[v].n);
      run_to_done(2000, lat);
      finish_checks($sformatf("vec%0d", v), int'(vecs[v].n), vecs[v].mx, vecs[v].mn,
                    vecs[v].av, vecs[v].sm, int'(vecs[v].lat), lat);
    end

    // Mid-FETCH reset after 2 of 5 elements.
    stim     = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    gap_len  = 0;
    poke_cyc = 0;
    begin_run(8'd5);
    for (int g = 0; g < 20 && idx < 2; g++) drive_cycle();
    check("abort consumed", idx, 2);
    RESET      = 1'b1;
    data_valid = 1'b1;
    data_in    = 8'd3;
    #1;
    check("abort ready_drop", data_ready, 0);
    check("abort dec_drop",   Count_dec, 0);
    check("abort load_drop",  Count_load, 0);
    @(posedge CLK);
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort sum",  sum_out, 0);
    check("abort max",  max_out, 0);
    check("abort min",  min_out, 0);
    check("abort count_in", Count_in, 0);
    RESET      = 1'b0;
    data_valid = 1'b0;
    @(posedge CLK);
    #1;
    check("abort no_done", done_cnt - done0, 0);
    stim = '{8'd4, 8'd6};
    begin_run(8'd2);
    run_to_done(2000, lat);
    finish_checks("after_abort", 2, 8'd6, 8'd4, 8'd5, 16'd10, 21, lat);

    // Randomized runs against the reference model.
    for (int r = 0; r < 12; r++) begin
      int n;
      n = (r == 0) ? 0 : $urandom_range(1, 20);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
      gap_len  = $urandom_range(0, 2);
      poke_cyc = (r % 3 == 1) ? $urandom_range(2, 10) : 0;
      model(stim, mx, mn, av, sm);
      begin_run(8'(n));
      run_to_done(2000, lat);
      finish_checks($sformatf("rand%0d", r), n, mx, mn, av, sm,
                    (gap_len == 0) ? ((n == 0) ? 1 : 3 + n + SW) : 0, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
